// File: rtl/countdown_sequencer.sv
// Countdown timer control: debounces the start/next buttons and sequences
// set -> arm -> run/pause -> done, driving counter strobes, display and LEDs.
module countdown_sequencer #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned BLINK_HZ        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnL,
  input  logic        btnR,
  input  logic [7:0]  sw,
  input  logic        count_is_zero,
  output logic [7:0]  load_value,
  output logic        cnt_load,
  output logic        cnt_enable,
  output logic        disp_enable,
  output logic        disp_sel,
  output logic [15:0] led,
  output logic [2:0]  state
);

  localparam int unsigned TICK_CNT  = CLK_HZ / TICK_HZ;
  localparam int unsigned BLINK_CNT = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PRE_W     = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int unsigned BLK_W     = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
  localparam int unsigned DB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETVAL = 3'd1,
    S_ARMED  = 3'd2,
    S_RUN    = 3'd3,
    S_PAUSE  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Button front end: bit 0 = btnL (start), bit 1 = btnR (next)
  logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q, pulse_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic            start_p, next_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {btnR, btnL};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
      // Any cycle where the synchronized level agrees restarts the stability count
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign start_p = pulse_q[0];
  assign next_p  = pulse_q[1];

  state_e           state_q, state_d;
  logic [7:0]       load_value_q, load_value_d;
  logic             cnt_load_q, cnt_load_d;
  logic             cnt_enable_q, cnt_enable_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [BLK_W-1:0] blink_q, blink_d;
  logic [15:0]      led_q, led_d;

  always_comb begin
    state_d      = state_q;
    load_value_d = load_value_q;
    cnt_load_d   = 1'b0;
    cnt_enable_d = 1'b0;
    presc_d      = presc_q;
    blink_d      = '0;
    led_d        = '0;

    if (state_q == S_SETVAL) load_value_d = sw;

    if (start_p) begin
      state_d = S_SETVAL;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_SETVAL: begin
          if (next_p) begin
            state_d    = S_ARMED;
            cnt_load_d = 1'b1;
          end
        end
        S_ARMED: begin
          if (next_p) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          // Decrement gated at zero so the counter never wraps
          if (presc_q == PRE_W'(TICK_CNT - 1)) begin
            presc_d      = '0;
            cnt_enable_d = ~count_is_zero;
          end else begin
            presc_d = presc_q + PRE_W'(1);
          end
          if (count_is_zero)  state_d = S_DONE;
          else if (next_p)    state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (next_p) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_DONE: begin
          if (next_p) begin
            state_d    = S_ARMED;
            cnt_load_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // LED flash: all-ones on DONE entry, then toggle every BLINK_CNT cycles
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        led_d = '1;
      end else if (blink_q == BLK_W'(BLINK_CNT - 1)) begin
        led_d = ~led_q;
      end else begin
        led_d   = led_q;
        blink_d = blink_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_value_q <= '0;
      cnt_load_q   <= 1'b0;
      cnt_enable_q <= 1'b0;
      presc_q      <= '0;
      blink_q      <= '0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      load_value_q <= load_value_d;
      cnt_load_q   <= cnt_load_d;
      cnt_enable_q <= cnt_enable_d;
      presc_q      <= presc_d;
      blink_q      <= blink_d;
      led_q        <= led_d;
    end
  end

  assign load_value  = load_value_q;
  assign cnt_load    = cnt_load_q;
  assign cnt_enable  = cnt_enable_q;
  assign led         = led_q;
  assign state       = state_q;
  assign disp_enable = (state_q == S_ARMED) || (state_q == S_RUN) ||
                       (state_q == S_PAUSE) || (state_q == S_DONE);
  assign disp_sel    = (state_q == S_RUN) || (state_q == S_PAUSE) || (state_q == S_DONE);

endmodule
